// File: rtl/holy_axi_lite_timer.sv
// holy_axi_lite_timer: AXI-Lite subordinate hosting a programmable down-counter timer with a level interrupt
module holy_axi_lite_timer #(
    parameter int ADDR_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [ADDR_WIDTH-1:0] s_axi_lite_awaddr,
    input  logic                  s_axi_lite_awvalid,
    output logic                  s_axi_lite_awready,
    input  logic [31:0]           s_axi_lite_wdata,
    input  logic [3:0]            s_axi_lite_wstrb,
    input  logic                  s_axi_lite_wvalid,
    output logic                  s_axi_lite_wready,
    output logic [1:0]            s_axi_lite_bresp,
    output logic                  s_axi_lite_bvalid,
    input  logic                  s_axi_lite_bready,
    input  logic [ADDR_WIDTH-1:0] s_axi_lite_araddr,
    input  logic                  s_axi_lite_arvalid,
    output logic                  s_axi_lite_arready,
    output logic [31:0]           s_axi_lite_rdata,
    output logic [1:0]            s_axi_lite_rresp,
    output logic                  s_axi_lite_rvalid,
    input  logic                  s_axi_lite_rready,
    output logic                  irq
);
    logic [2:0]  ctrl_q, ctrl_d;
    logic [31:0] load_q, load_d, count_q, count_d;
    logic        expired_q, expired_d;
    logic        aw_held_q, aw_held_d, aw_err_q, aw_err_d;
    logic [1:0]  aw_sel_q, aw_sel_d;
    logic        w_held_q, w_held_d;
    logic [31:0] w_data_q, w_data_d;
    logic [3:0]  w_strb_q, w_strb_d;
    logic        bvalid_q, bvalid_d, rvalid_q, rvalid_d;
    logic [1:0]  bresp_q, bresp_d, rresp_q, rresp_d;
    logic [31:0] rdata_q, rdata_d;
    logic        aw_fire, w_fire, ar_fire, wr_go, wr_ok, wr_err, rd_err, expire, w1c;
    logic [1:0]  wr_sel, rd_sel;
    logic [31:0] wr_data, rd_val, step;
    logic [3:0]  wr_strb;
    logic        unused_addr_bits;

    assign s_axi_lite_awready = !aw_held_q && !bvalid_q;
    assign s_axi_lite_wready  = !w_held_q && !bvalid_q;
    assign s_axi_lite_arready = !rvalid_q;
    assign s_axi_lite_bvalid  = bvalid_q;
    assign s_axi_lite_bresp   = bresp_q;
    assign s_axi_lite_rvalid  = rvalid_q;
    assign s_axi_lite_rdata   = rdata_q;
    assign s_axi_lite_rresp   = rresp_q;
    assign irq                = expired_q && ctrl_q[1];
    assign aw_fire            = s_axi_lite_awvalid && s_axi_lite_awready;
    assign w_fire             = s_axi_lite_wvalid && s_axi_lite_wready;
    assign unused_addr_bits   = ^{s_axi_lite_awaddr[1:0], s_axi_lite_araddr[1:0]};

    // Write channel: AW and W park in one-entry holds; the write commits the cycle both are present
    always_comb begin
        wr_sel    = aw_held_q ? aw_sel_q : s_axi_lite_awaddr[3:2];
        wr_err    = aw_held_q ? aw_err_q : (s_axi_lite_awaddr >> 4) != '0;
        wr_data   = w_held_q ? w_data_q : s_axi_lite_wdata;
        wr_strb   = w_held_q ? w_strb_q : s_axi_lite_wstrb;
        wr_go     = (aw_held_q || aw_fire) && (w_held_q || w_fire);
        wr_ok     = wr_go && !wr_err;
        aw_held_d = (aw_held_q || aw_fire) && !wr_go;
        aw_sel_d  = wr_sel;
        aw_err_d  = wr_err;
        w_held_d  = (w_held_q || w_fire) && !wr_go;
        w_data_d  = wr_data;
        w_strb_d  = wr_strb;
        bvalid_d  = wr_go || (bvalid_q && !s_axi_lite_bready);
        bresp_d   = wr_go ? {wr_err, 1'b0} : bresp_q;
    end

    // Register updates and counter step; bus LOAD writes override the step, expiry beats W1C
    always_comb begin
        w1c       = wr_ok && wr_sel == 2'd3 && wr_strb[0] && wr_data[0];
        expire    = ctrl_q[0] && count_q == 32'd1;
        step      = !ctrl_q[0] ? count_q : count_q > 32'd1 ? count_q - 32'd1 : expire ? (ctrl_q[2] ? load_q : '0) : count_q;
        ctrl_d    = (wr_ok && wr_sel == 2'd0 && wr_strb[0]) ? wr_data[2:0] : ctrl_q;
        load_d    = load_q;
        for (int i = 0; i < 4; i++)
            load_d[8*i +: 8] = (wr_ok && wr_sel == 2'd1 && wr_strb[i]) ? wr_data[8*i +: 8] : load_q[8*i +: 8];
        count_d   = (wr_ok && wr_sel == 2'd1) ? load_d : step;
        expired_d = expire || (expired_q && !w1c);
    end

    // Read channel: register the addressed value on AR and hold it until accepted
    always_comb begin
        rd_sel   = s_axi_lite_araddr[3:2];
        rd_err   = (s_axi_lite_araddr >> 4) != '0;
        rd_val   = rd_sel == 2'd0 ? {29'd0, ctrl_q} : rd_sel == 2'd1 ? load_q : rd_sel == 2'd2 ? count_q : {31'd0, expired_q};
        ar_fire  = s_axi_lite_arvalid && !rvalid_q;
        rvalid_d = ar_fire || (rvalid_q && !s_axi_lite_rready);
        rdata_d  = ar_fire ? (rd_err ? '0 : rd_val) : rdata_q;
        rresp_d  = ar_fire ? {rd_err, 1'b0} : rresp_q;
    end

    // State registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            ctrl_q    <= '0;
            load_q    <= '0;
            count_q   <= '0;
            expired_q <= 1'b0;
            aw_held_q <= 1'b0;
            aw_sel_q  <= '0;
            aw_err_q  <= 1'b0;
            w_held_q  <= 1'b0;
            w_data_q  <= '0;
            w_strb_q  <= '0;
            bvalid_q  <= 1'b0;
            bresp_q   <= '0;
            rvalid_q  <= 1'b0;
            rdata_q   <= '0;
            rresp_q   <= '0;
        end else begin
            ctrl_q    <= ctrl_d;
            load_q    <= load_d;
            count_q   <= count_d;
            expired_q <= expired_d;
            aw_held_q <= aw_held_d;
            aw_sel_q  <= aw_sel_d;
            aw_err_q  <= aw_err_d;
            w_held_q  <= w_held_d;
            w_data_q  <= w_data_d;
            w_strb_q  <= w_strb_d;
            bvalid_q  <= bvalid_d;
            bresp_q   <= bresp_d;
            rvalid_q  <= rvalid_d;
            rdata_q   <= rdata_d;
            rresp_q   <= rresp_d;
        end
    end
endmodule

// File: tb/tb_holy_axi_lite_timer.sv
// tb_holy_axi_lite_timer: scoreboard bench for the AXI-Lite timer against a closed-form timer model
module tb_holy_axi_lite_timer;
    localparam int AW = 32;

    typedef struct packed {
        logic [31:0] d;
        logic [1:0]  r;
    } rsp_t;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [AW-1:0] awaddr = '0, araddr = '0;
    logic          awvalid = 1'b0, wvalid = 1'b0, arvalid = 1'b0, bready = 1'b1, rready = 1'b1;
    logic [31:0]   wdata = '0;
    logic [3:0]    wstrb = '0;
    logic          awready, wready, bvalid, arready, rvalid, irq;
    logic [1:0]    bresp, rresp;
    logic [31:0]   rdata;

    int   cyc = 0;
    int   n_checks = 0;
    int   n_fail = 0;
    rsp_t rq[$];
    logic [1:0] bq[$];
    rsp_t mon_r;
    logic [1:0] mon_b;

    // Timer model: state captured at cycle m_t0, later values derived arithmetically
    logic [2:0]  m_ctrl;
    logic [31:0] m_load, m_cnt0;
    logic        m_exp0;
    int          m_t0;

    logic [AW-1:0] ra;
    logic [31:0]   rd_d;
    logic [3:0]    rs;
    int            target;

    holy_axi_lite_timer #(.ADDR_WIDTH(AW)) dut (
        .clk(clk), .rst(rst),
        .s_axi_lite_awaddr(awaddr), .s_axi_lite_awvalid(awvalid), .s_axi_lite_awready(awready),
        .s_axi_lite_wdata(wdata), .s_axi_lite_wstrb(wstrb), .s_axi_lite_wvalid(wvalid), .s_axi_lite_wready(wready),
        .s_axi_lite_bresp(bresp), .s_axi_lite_bvalid(bvalid), .s_axi_lite_bready(bready),
        .s_axi_lite_araddr(araddr), .s_axi_lite_arvalid(arvalid), .s_axi_lite_arready(arready),
        .s_axi_lite_rdata(rdata), .s_axi_lite_rresp(rresp), .s_axi_lite_rvalid(rvalid), .s_axi_lite_rready(rready),
        .irq(irq)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic fail(input string name);
        n_checks++;
        n_fail++;
        $display("FAIL %s: got timeout, expected handshake (cycle %0d)", name, cyc);
    endtask

    function automatic logic [31:0] count_at(input int t);
        longint k = longint'(t - m_t0);
        if (!m_ctrl[0] || m_cnt0 == 0) return m_cnt0;
        if (k < longint'(m_cnt0)) return m_cnt0 - 32'(k);
        if (!m_ctrl[2] || m_load == 0) return 32'd0;
        return m_load - 32'((k - longint'(m_cnt0)) % longint'(m_load));
    endfunction

    function automatic logic exp_at(input int t);
        return m_exp0 || (m_ctrl[0] && m_cnt0 != 0 && longint'(t - m_t0) >= longint'(m_cnt0));
    endfunction

    function automatic logic exp_edge(input int t);
        longint k = longint'(t - m_t0);
        longint c = longint'(m_cnt0);
        if (!m_ctrl[0] || m_cnt0 == 0 || k < c) return 1'b0;
        return k == c || (m_ctrl[2] && m_load != 0 && (k - c) % longint'(m_load) == 0);
    endfunction

    function automatic logic [31:0] exp_reg(input logic [1:0] sel, input int t);
        return sel == 2'd0 ? {29'd0, m_ctrl} : sel == 2'd1 ? m_load : sel == 2'd2 ? count_at(t) : {31'd0, exp_at(t)};
    endfunction

    task automatic model_reset();
        m_ctrl = '0;
        m_load = '0;
        m_cnt0 = '0;
        m_exp0 = 1'b0;
        m_t0   = cyc;
    endtask

    task automatic model_write(input int tc, input logic [AW-1:0] a, input logic [31:0] d, input logic [3:0] s);
        logic [31:0] c = count_at(tc);
        logic        e = exp_at(tc);
        logic        ed = exp_edge(tc);
        if ((a >> 4) == 0) begin
            if (a[3:2] == 2'd0 && s[0]) m_ctrl = d[2:0];
            if (a[3:2] == 2'd1) begin
                for (int b = 0; b < 4; b++) if (s[b]) m_load[8*b +: 8] = d[8*b +: 8];
                c = m_load;
            end
            if (a[3:2] == 2'd3 && s[0] && d[0] && !ed) e = 1'b0;
        end
        m_cnt0 = c;
        m_exp0 = e;
        m_t0   = tc;
    endtask

    task automatic wr(input logic [AW-1:0] a, input logic [31:0] d, input logic [3:0] s,
                      input int aw_dl, input int w_dl, input int w_at);
        int s0, n, i;
        bit aw_done, w_done;
        n = 0;
        i = 0;
        aw_done = 0;
        w_done = 0;
        bq.push_back((a >> 4) != 0 ? 2'b10 : 2'b00);
        @(posedge clk);
        #1;
        s0 = cyc;
        if (w_at >= 0) w_dl = w_at - s0;
        awaddr = a;
        wdata  = d;
        wstrb  = s;
        while (!(aw_done && w_done) && i < 40) begin
            awvalid = !aw_done && i >= aw_dl;
            wvalid  = !w_done && i >= w_dl;
            @(negedge clk);
            if (awvalid && awready) aw_done = 1;
            if (wvalid && wready) w_done = 1;
            n = cyc;
            @(posedge clk);
            #1;
            i++;
        end
        awvalid = 1'b0;
        wvalid  = 1'b0;
        if (!(aw_done && w_done)) begin
            fail("write_handshake");
            void'(bq.pop_back());
            return;
        end
        @(negedge clk);
        check("b_latency", {31'd0, bvalid}, 32'd1);
        model_write(n + 1, a, d, s);
        check("irq_after_write", {31'd0, irq}, {31'd0, exp_at(cyc) && m_ctrl[1]});
    endtask

    task automatic rd(input logic [AW-1:0] a);
        int n, budget;
        budget = 0;
        @(posedge clk);
        #1;
        araddr  = a;
        arvalid = 1'b1;
        @(negedge clk);
        while (!arready && budget < 20) begin
            @(negedge clk);
            budget++;
        end
        if (!arready) begin
            fail("read_handshake");
            arvalid = 1'b0;
            return;
        end
        n = cyc;
        rq.push_back((a >> 4) != 0 ? {32'd0, 2'b10} : {exp_reg(a[3:2], n), 2'b00});
        check("irq_at_read", {31'd0, irq}, {31'd0, exp_at(n) && m_ctrl[1]});
        @(posedge clk);
        #1;
        arvalid = 1'b0;
        @(negedge clk);
        check("r_latency", {31'd0, rvalid}, 32'd1);
    endtask

    // Monitor: pop the oldest expected response whenever the DUT completes a response handshake
    always @(negedge clk) begin
        if (!rst && rvalid && rready) begin
            if (rq.size() == 0) fail("unexpected_r");
            else begin
                mon_r = rq.pop_front();
                check("rdata", rdata, mon_r.d);
                check("rresp", {30'd0, rresp}, {30'd0, mon_r.r});
            end
        end
        if (!rst && bvalid && bready) begin
            if (bq.size() == 0) fail("unexpected_b");
            else begin
                mon_b = bq.pop_front();
                check("bresp", {30'd0, bresp}, {30'd0, mon_b});
            end
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: got no end of test, expected completion (cycle %0d)", cyc);
        $fatal(1);
    end

    initial begin
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
        @(negedge clk);
        check("awready_rst", {31'd0, awready}, 32'd1);
        check("wready_rst", {31'd0, wready}, 32'd1);
        check("arready_rst", {31'd0, arready}, 32'd1);
        check("bvalid_rst", {31'd0, bvalid}, 32'd0);
        check("rvalid_rst", {31'd0, rvalid}, 32'd0);
        check("rdata_rst", rdata, 32'd0);
        check("irq_rst", {31'd0, irq}, 32'd0);
        for (int i = 0; i < 4; i++) rd(AW'(4 * i));

        wr(32'h4, 32'd5, 4'hF, 0, 3, -1);
        rd(32'h8);
        wr(32'h4, 32'hFFFF_FFAA, 4'b0001, 0, 0, -1);
        rd(32'h4);

        wr(32'h4, 32'd3, 4'hF, 1, 0, -1);
        wr(32'h0, 32'h3, 4'hF, 0, 0, -1);
        repeat (6) begin
            @(negedge clk);
            check("irq_run", {31'd0, irq}, {31'd0, exp_at(cyc) && m_ctrl[1]});
        end
        rd(32'h8);
        rd(32'hC);
        wr(32'hC, 32'h1, 4'h1, 0, 0, -1);
        rd(32'hC);

        wr(32'h0, 32'h0, 4'hF, 0, 0, -1);
        wr(32'h4, 32'd2, 4'hF, 0, 0, -1);
        wr(32'h0, 32'h7, 4'hF, 0, 0, -1);
        rd(32'h8);
        rd(32'hC);
        @(posedge clk);
        rd(32'h8);
        rd(32'h8);
        rd(32'hC);
        target = m_t0 + 1;
        while (target < cyc + 2) target += 2;
        wr(32'hC, 32'h1, 4'h1, 0, 0, target);
        rd(32'hC);
        rd(32'h9);

        for (int i = 0; i < 60; i++) begin
            ra = AW'((($urandom % 4) << 2) | ($urandom % 4));
            if ($urandom % 8 == 0) ra = ra | AW'($urandom_range(1, 255) << 4);
            if ($urandom % 2 == 0) rd(ra);
            else begin
                rd_d = $urandom;
                if (ra[3:2] == 2'd1 && $urandom % 2 == 0) rd_d = $urandom_range(0, 6);
                rs = ($urandom % 2 == 0) ? 4'hF : 4'($urandom);
                wr(ra, rd_d, rs, $urandom_range(0, 3), $urandom_range(0, 3), -1);
            end
            repeat ($urandom % 3) @(posedge clk);
        end

        rd(32'h10);
        bready = 1'b0;
        wr(32'h14, 32'hFF, 4'hF, 0, 0, -1);
        repeat (4) begin
            @(negedge clk);
            check("b_hold_valid", {31'd0, bvalid}, 32'd1);
            check("b_hold_resp", {30'd0, bresp}, 32'd2);
            check("awready_stall", {31'd0, awready}, 32'd0);
            check("wready_stall", {31'd0, wready}, 32'd0);
        end
        @(posedge clk);
        #1;
        bready = 1'b1;
        for (int i = 0; i < 4; i++) rd(AW'(4 * i));

        wr(32'h4, 32'd9, 4'hF, 0, 0, -1);
        wr(32'h0, 32'h3, 4'hF, 0, 0, -1);
        rready = 1'b0;
        rd(32'h8);
        rst = 1'b1;
        @(negedge clk);
        check("rvalid_abort", {31'd0, rvalid}, 32'd0);
        check("bvalid_abort", {31'd0, bvalid}, 32'd0);
        rq.delete();
        bq.delete();
        @(posedge clk);
        #1;
        rst = 1'b0;
        rready = 1'b1;
        model_reset();
        @(negedge clk);
        check("arready_after_rst", {31'd0, arready}, 32'd1);
        check("awready_after_rst", {31'd0, awready}, 32'd1);
        check("irq_after_rst", {31'd0, irq}, 32'd0);
        for (int i = 0; i < 4; i++) rd(AW'(4 * i));

        repeat (3) @(negedge clk);
        check("r_queue_empty", rq.size(), 32'd0);
        check("b_queue_empty", bq.size(), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
